// File: rtl/uart_tx_serializer_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
// uart_tx_serializer_pkg : shared UART transmit types and line levels
// Rev 1.0
// =====================================================================
package uart_tx_serializer_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      FETCH  = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } uart_tx_state_e;

   typedef enum logic [1:0] {
      PAR_NONE = 2'd0,
      PAR_EVEN = 2'd1,
      PAR_ODD  = 2'd2
   } uart_parity_e;

   localparam logic UART_IDLE_LEVEL  = 1'b1;
   localparam logic UART_START_LEVEL = 1'b0;

endpackage
`default_nettype wire

// File: rtl/uart_tx_serializer_baud_gen.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
// uart_baud_gen : bit-period counter, ticks on the last cycle of a bit
// Rev 1.0
// =====================================================================
module uart_baud_gen #(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic clk,
   input  logic sync_rst,
   input  logic clk_en,
   input  logic restart_i,
   output logic bit_tick_o
);

   localparam int               CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             cnt_last;

   assign cnt_last   = (cnt_q == CNT_LAST);
   assign bit_tick_o = clk_en & cnt_last;

   always_comb begin
      cnt_d = cnt_q;
      if (clk_en) begin
         cnt_d = (restart_i | cnt_last) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_tx_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
// uart_tx_serializer : pops TX FIFO words and drives framed serial data
// Rev 1.0
// =====================================================================
module uart_tx_serializer
   import uart_tx_serializer_pkg::*;
#(
   parameter int FIFO_DATA_WIDTH = 16,
   parameter int DATA_BITS       = 8,
   parameter int CLKS_PER_BIT    = 16,
   parameter int PARITY_MODE     = 0,
   parameter int STOP_BITS       = 1
) (
   input  logic                       clk,
   input  logic                       sync_rst,
   input  logic                       clk_en,
   input  logic                       fifo_empty,
   input  logic [FIFO_DATA_WIDTH-1:0] fifo_data,
   output logic                       fifo_rd_en,
   output logic                       tx,
   output logic                       busy,
   output logic                       frame_done
);

   localparam int               BIT_W     = $clog2(DATA_BITS + 1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

   generate
      if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
         $error("uart_tx_serializer: DATA_BITS must be 5..9");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
         $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
      end
      if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
         $error("uart_tx_serializer: PARITY_MODE must be 0, 1 or 2");
      end
      if (CLKS_PER_BIT < 2 || FIFO_DATA_WIDTH < DATA_BITS) begin : g_bad_geometry
         $error("uart_tx_serializer: CLKS_PER_BIT >= 2 and FIFO_DATA_WIDTH >= DATA_BITS required");
      end
   endgenerate

   uart_tx_state_e       state_q, state_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]     bitcnt_q, bitcnt_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 bit_tick;
   logic [DATA_BITS-1:0] word;
   logic                 unused_fifo_bits;

   assign word             = fifo_data[DATA_BITS-1:0];
   assign unused_fifo_bits = ^fifo_data;

   assign fifo_rd_en = (state_q == IDLE) & ~fifo_empty & clk_en & ~sync_rst;
   assign tx         = tx_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk        (clk),
      .sync_rst   (sync_rst),
      .clk_en     (clk_en),
      .restart_i  (state_q == FETCH),
      .bit_tick_o (bit_tick)
   );

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      par_d    = par_q;
      done_d   = 1'b0;
      tx_d     = UART_IDLE_LEVEL;
      busy_d   = 1'b0;
      if (clk_en) begin
         case (state_q)
            IDLE: begin
               if (!fifo_empty) state_d = FETCH;
            end
            FETCH: begin
               shreg_d  = word;
               par_d    = (PARITY_MODE == int'(PAR_ODD)) ? ~^word : ^word;
               bitcnt_d = '0;
               state_d  = START;
            end
            START: begin
               if (bit_tick) state_d = DATA;
            end
            DATA: begin
               if (bit_tick) begin
                  shreg_d = shreg_q >> 1;
                  if (bitcnt_q == DATA_LAST) begin
                     bitcnt_d = '0;
                     state_d  = (PARITY_MODE == int'(PAR_NONE)) ? STOP : PARITY;
                  end else begin
                     bitcnt_d = bitcnt_q + BIT_W'(1);
                  end
               end
            end
            PARITY: begin
               if (bit_tick) state_d = STOP;
            end
            STOP: begin
               // bitcnt doubles as the stop-bit counter
               if (bit_tick) begin
                  if (bitcnt_q == STOP_LAST) begin
                     bitcnt_d = '0;
                     done_d   = 1'b1;
                     state_d  = IDLE;
                  end else begin
                     bitcnt_d = bitcnt_q + BIT_W'(1);
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
      // line level is registered, so it follows the state being entered
      case (state_d)
         START:   tx_d = UART_START_LEVEL;
         DATA:    tx_d = shreg_d[0];
         PARITY:  tx_d = par_d;
         default: tx_d = UART_IDLE_LEVEL;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitcnt_q <= '0;
         par_q    <= 1'b0;
         tx_q     <= UART_IDLE_LEVEL;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= done_d;
         if (clk_en) begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_serializer.sv
`default_nettype none
`timescale 1ns/1ps
// =====================================================================
// tb_uart_tx_serializer : three configurations checked against a frame-level line model
// Rev 1.0
// =====================================================================
module tb_uart_tx_serializer;

   localparam int NI  = 3;
   localparam int CPB = 4;
   localparam int WIN = 128;

   // cfg0: no parity, 1 stop; cfg1: even parity, 2 stop; cfg2: odd parity, 1 stop
   function automatic int par_of(input int i);
      return (i == 1) ? 1 : ((i == 2) ? 2 : 0);
   endfunction
   function automatic int stop_of(input int i);
      return (i == 1) ? 2 : 1;
   endfunction

   logic        clk = 1'b0;
   logic        sync_rst;
   logic        clk_en;
   logic [15:0] mem [64];
   int          wr_cnt;
   logic        chk_on;
   int          checks;
   int          errors;
   int          ncyc = 0;
   int          win_start = -100000;

   logic        fifo_empty_w [NI];
   logic        rd_w   [NI];
   logic        tx_w   [NI];
   logic        busy_w [NI];
   logic        done_w [NI];

   logic        tx_s   [NI][WIN];
   logic        busy_s [NI][WIN];
   logic        done_s [NI][WIN];
   logic        rd_s   [NI][WIN];

   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [7:0] w);
      mem[wr_cnt] = {~w, w};
      wr_cnt++;
   endtask

   // which: 0 = tx low, 1 = busy high, 2 = frame_done high, 3 = fifo_rd_en high
   function automatic int count(input int i, input int which, input int lo, input int hi);
      int n = 0;
      for (int k = lo; k <= hi; k++) begin
         if (which == 0)      n += int'(tx_s[i][k] === 1'b0);
         else if (which == 1) n += int'(busy_s[i][k] === 1'b1);
         else if (which == 2) n += int'(done_s[i][k] === 1'b1);
         else                 n += int'(rd_s[i][k] === 1'b1);
      end
      return n;
   endfunction

   function automatic int wave_err(input int i, input int k0, input int per, input logic [9:0] pat);
      int e = 0;
      for (int k = k0; k < k0 + 10 * per; k++) begin
         if (tx_s[i][k] !== pat[(k - k0) / per]) e++;
      end
      return e;
   endfunction

   always @(negedge clk) begin
      int k;
      k = ncyc - win_start;
      if (k >= 0 && k < WIN) begin
         for (int i = 0; i < NI; i++) begin
            tx_s[i][k]   = tx_w[i];
            busy_s[i][k] = busy_w[i];
            done_s[i][k] = done_w[i];
            rd_s[i][k]   = rd_w[i];
         end
      end
      ncyc++;
   end

   for (genvar gi = 0; gi < NI; gi++) begin : g_cfg
      localparam int P = par_of(gi);
      localparam int S = stop_of(gi);

      int          rp   = 0;
      int          mptr = 0;
      logic [15:0] fd   = '0;
      logic [2:0]  q [$];
      logic [2:0]  cur  = 3'b100;   // {tx, busy, frame_done}
      logic        rd_x;

      assign fifo_empty_w[gi] = (rp == wr_cnt);

      uart_tx_serializer #(
         .FIFO_DATA_WIDTH (16),
         .DATA_BITS       (8),
         .CLKS_PER_BIT    (CPB),
         .PARITY_MODE     (P),
         .STOP_BITS       (S)
      ) u_dut (
         .clk        (clk),
         .sync_rst   (sync_rst),
         .clk_en     (clk_en),
         .fifo_empty (fifo_empty_w[gi]),
         .fifo_data  (fd),
         .fifo_rd_en (rd_w[gi]),
         .tx         (tx_w[gi]),
         .busy       (busy_w[gi]),
         .frame_done (done_w[gi])
      );

      always @(posedge clk) begin
         if (rd_w[gi] === 1'b1) begin
            fd <= mem[rp];
            rp <= rp + 1;
         end
      end

      // Each enabled edge consumes one queued output triple; a popped word
      // expands into FETCH, every frame bit CPB times, then the IDLE/done cycle.
      always @(negedge clk) begin
         logic [7:0] d;
         int         nb;
         logic       bits [12];
         logic [2:0] e;
         rd_x = (q.size() == 0) && (mptr != wr_cnt) && clk_en && !sync_rst;
         if (chk_on) begin
            chk($sformatf("cfg%0d tx", gi), int'(tx_w[gi]), int'(cur[2]));
            chk($sformatf("cfg%0d busy", gi), int'(busy_w[gi]), int'(cur[1]));
            chk($sformatf("cfg%0d frame_done", gi), int'(done_w[gi]), int'(cur[0]));
            chk($sformatf("cfg%0d fifo_rd_en", gi), int'(rd_w[gi]), int'(rd_x));
         end
         if (sync_rst) begin
            q.delete();
            cur = 3'b100;
         end else if (!clk_en) begin
            cur[0] = 1'b0;
         end else begin
            if (rd_x) begin
               d = mem[mptr][7:0];
               mptr++;
               nb = 0;
               bits[nb] = 1'b0; nb++;
               for (int b = 0; b < 8; b++) begin
                  bits[nb] = d[b]; nb++;
               end
               if (P == 1) begin
                  bits[nb] = ^d; nb++;
               end else if (P == 2) begin
                  bits[nb] = ~^d; nb++;
               end
               for (int s = 0; s < S; s++) begin
                  bits[nb] = 1'b1; nb++;
               end
               q.push_back(3'b110);
               for (int j = 0; j < nb; j++) begin
                  for (int c = 0; c < CPB; c++) q.push_back({bits[j], 2'b10});
               end
               q.push_back(3'b101);
            end
            if (q.size() != 0) begin
               e   = q.pop_front();
               cur = e;
            end else begin
               cur = 3'b100;
            end
         end
      end
   end

   initial begin
      checks   = 0;
      errors   = 0;
      chk_on   = 1'b0;
      wr_cnt   = 0;
      sync_rst = 1'b1;
      clk_en   = 1'b1;
      @(posedge clk);
      #1;
      chk_on = 1'b1;
      cyc(2);
      chk("reset tx", int'(tx_w[0]), 1);
      chk("reset busy", int'(busy_w[0]), 0);
      chk("reset frame_done", int'(done_w[0]), 0);
      sync_rst = 1'b0;
      cyc(4);

      // 0x55, no parity: start + 8 data + stop, 4 cycles each
      win_start = ncyc;
      push(8'h55);
      cyc(60);
      chk("t1 wave 0x55", wave_err(0, 2, CPB, 10'b1010101010), 0);
      chk("t1 tx idle k1", int'(tx_s[0][1]), 1);
      chk("t1 busy in FETCH", int'(busy_s[0][1]), 1);
      chk("t1 frame_done@42", int'(done_s[0][42]), 1);
      chk("t1 no early done", count(0, 2, 0, 41), 0);
      chk("t1 busy low@42", int'(busy_s[0][42]), 0);
      chk("t1 rd pulses", count(0, 3, 0, 59), 1);

      // 0x07 has three ones: even parity bit 1, odd parity bit 0
      win_start = ncyc;
      push(8'h07);
      cyc(60);
      chk("t2 even parity bit", int'(tx_s[1][39]), 1);
      chk("t2 odd parity bit", int'(tx_s[2][39]), 0);
      chk("t2 odd frame_done@46", int'(done_s[2][46]), 1);
      chk("t2 odd no early done", count(2, 2, 0, 45), 0);
      chk("t2 even 2-stop done@50", int'(done_s[1][50]), 1);

      // back-to-back 0xA5, 0x3C on the 2-stop configuration
      win_start = ncyc;
      push(8'hA5);
      push(8'h3C);
      cyc(110);
      chk("t3 parity of A5", int'(tx_s[1][41]), 0);
      chk("t3 stop2 high", int'(tx_s[1][49]), 1);
      chk("t3 done@50", int'(done_s[1][50]), 1);
      chk("t3 gap idle k50", int'(tx_s[1][50]), 1);
      chk("t3 gap fetch k51", int'(tx_s[1][51]), 1);
      chk("t3 second start k52", int'(tx_s[1][52]), 0);
      chk("t3 busy cycles 2..99", count(1, 1, 2, 99), 97);
      chk("t3 second done@100", int'(done_s[1][100]), 1);
      chk("t3 rd pulses", count(1, 3, 0, 109), 2);
      chk("t3 fifo empty", int'(fifo_empty_w[1]), 1);

      // 0x81 with clk_en alternating: every bit spans 2*CPB clocks
      win_start = ncyc;
      push(8'h81);
      for (int k = 1; k < 100; k++) begin
         @(posedge clk);
         #1;
         clk_en = (k % 2 == 0);
      end
      clk_en = 1'b1;
      cyc(40);
      chk("t4 wave 0x81", wave_err(0, 3, 2 * CPB, 10'b1100000010), 0);
      chk("t4 tx high k2", int'(tx_s[0][2]), 1);
      chk("t4 busy@82", int'(busy_s[0][82]), 1);
      chk("t4 done@83", int'(done_s[0][83]), 1);
      chk("t4 done one cycle", int'(done_s[0][84]), 0);
      chk("t4 busy low@83", int'(busy_s[0][83]), 0);
      chk("t4 rd pulses", count(0, 3, 0, 99), 1);
      chk("t4 odd parity of 81", int'(tx_s[2][78]), 1);

      // reset during data bit 3, then the next word goes out cleanly
      win_start = ncyc;
      push(8'h55);
      push(8'h3C);
      cyc(19);
      sync_rst = 1'b1;
      cyc(1);
      sync_rst = 1'b0;
      cyc(70);
      chk("t5 bit3 of 55", int'(tx_s[0][19]), 0);
      chk("t5 tx after reset", int'(tx_s[0][20]), 1);
      chk("t5 busy after reset", int'(busy_s[0][20]), 0);
      chk("t5 no done for abandoned", count(0, 2, 0, 61), 0);
      chk("t5 wave 0x3C", wave_err(0, 22, CPB, 10'b1001111000), 0);
      chk("t5 done@62", int'(done_s[0][62]), 1);
      chk("t5 rd pulses", count(0, 3, 0, 89), 2);

      // empty FIFO for 100 cycles
      win_start = ncyc;
      cyc(100);
      chk("t6 no rd", count(0, 3, 0, 99), 0);
      chk("t6 tx never low", count(0, 0, 0, 99), 0);
      chk("t6 never busy", count(0, 1, 0, 99), 0);
      chk("t6 fifo empty", int'(fifo_empty_w[0]), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
